// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue path: control codes, RV32I
// opcode/funct7 constants and the packet handed from decode to execute.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'b0000,
    ALU_SUB      = 4'b0001,
    ALU_SLL      = 4'b0010,
    ALU_SLT      = 4'b0100,
    ALU_SLTU     = 4'b0110,
    ALU_XOR      = 4'b1000,
    ALU_SRL      = 4'b1010,
    ALU_SRA      = 4'b1011,
    ALU_OR       = 4'b1100,
    ALU_AND      = 4'b1110,
    ALU_PASS_OP1 = 4'b1101,
    ALU_PASS_OP2 = 4'b1111
  } alu_ctrl_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_ctrl_t         ctrl;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [4:0]        rd;
    logic              we;
    logic              illegal;
  } issue_pkt_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I OP / OP-IMM / LUI / AUIPC decoder producing the ALU
// control code, operand pair and writeback info for one instruction.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  output issue_pkt_t        pkt_o
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_u;
  logic [DATA_W-1:0] shamt;

  logic [3:0]        code;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              legal;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign shamt  = {27'b0, instr_i[24:20]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    code  = 4'b0000;
    op1   = '0;
    op2   = '0;
    legal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        op1   = rs1_i;
        op2   = rs2_i;
        code  = {funct3, funct7[5]};
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        op1 = rs1_i;
        if (funct3 == 3'b001) begin
          op2   = shamt;
          code  = {funct3, 1'b0};
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          op2   = shamt;
          code  = {funct3, funct7[5]};
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end else begin
          // Immediate bits 31:25 are part of the constant, so alt stays 0.
          op2   = imm_i;
          code  = {funct3, 1'b0};
          legal = 1'b1;
        end
      end
      OPC_LUI: begin
        op2   = imm_u;
        code  = ALU_PASS_OP2;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        op1   = pc_i;
        op2   = imm_u;
        code  = ALU_ADD;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign pkt_o.ctrl    = legal ? alu_ctrl_t'(code) : ALU_ADD;
  assign pkt_o.op1     = op1;
  assign pkt_o.op2     = op2;
  assign pkt_o.rd      = rd;
  assign pkt_o.we      = legal && (rd != 5'd0);
  assign pkt_o.illegal = !legal;

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage: decodes one instruction per accept and presents it
// to execute through a main + skid register pair so in_ready is a flop.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_ctrl,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  issue_pkt_t dec_pkt;
  issue_pkt_t main_q, main_d;
  issue_pkt_t skid_q, skid_d;
  logic       main_vld_q, main_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic       in_ready_q;
  logic       accept;
  logic       consume;

  alu_op_decoder u_decoder (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .rs1_i   (in_rs1),
    .rs2_i   (in_rs2),
    .pkt_o   (dec_pkt)
  );

  assign accept  = in_valid && in_ready_q && !flush;
  assign consume = main_vld_q && out_ready;

  // Skid is only ever filled while in_ready is low, so accept never
  // coincides with a skid-to-main move.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (consume) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = dec_pkt;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_d     = dec_pkt;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = dec_pkt;
        skid_vld_d = 1'b1;
      end
    end
  end

  // NOTE: state registers take non-blocking assignments only; the blocking
  // ones above live in always_comb and merely compute the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      // NOTE: payload registers are reset along with the valids so every
      // out_* field reads 0 straight out of reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= !skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_vld_q;
  assign out_ctrl    = main_q.ctrl;
  assign out_op1     = main_q.op1;
  assign out_op2     = main_q.op2;
  assign out_rd      = main_q.rd;
  assign out_we      = main_q.we;
  assign out_illegal = main_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage that drives the ALU's control and operand inputs. It accepts an instruction word, its PC and the two register-file read values over a valid/ready handshake. It decodes RV32I OP, OP-IMM, LUI and AUIPC into the 4-bit ALU control code and the operand pair, and presents them to the execute stage through a 2-entry skid buffer, so `in_ready` is a pure register output.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  discard all buffered entries; pulse.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction address.
- `in_rs1`, `in_rs2`  in  32 each  register-file read data for rs1/rs2, valid with `in_instr`.
- `out_valid`  out  1  entry presented to execute.
- `out_ready`  in  1  execute consumes entry.
- `out_ctrl`  out  4  ALU control code `{funct3, alt}`.
- `out_op1`, `out_op2`  out  32 each  ALU operands.
- `out_rd`  out  5  destination register.
- `out_we`  out  1  writeback enable.
- `out_illegal`  out  1  instruction not supported by this stage.

## Operation
- ALU control codes:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110.
  - XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
  - PASS_OP1 1101, PASS_OP2 1111.
- OP (0110011):
  - ctrl = `{funct3, funct7[5]}`.
  - op1 = rs1, op2 = rs2.
  - Legal only when funct7 = 0000000, or funct7 = 0100000 with funct3 ∈ {000, 101}.
- OP-IMM (0010011):
  - op1 = rs1.
  - funct3 ≠ 001/101: op2 = sign-extended `instr[31:20]`, alt = 0. ADDI never yields SUB.
  - SLLI (funct3 001): op2 = `{27'b0, instr[24:20]}`; legal only if funct7 = 0000000.
  - SRLI/SRAI (funct3 101): op2 = `{27'b0, instr[24:20]}`, alt = funct7[5]; legal only if funct7 = 0000000 or 0100000.
- LUI (0110111): ctrl = 1111, op1 = 0, op2 = `{instr[31:12], 12'b0}`.
- AUIPC (0010111): ctrl = 0000, op1 = pc, op2 = U-immediate.
- Any other opcode, or an illegal funct field:
  - `out_illegal` = 1, `out_we` = 0, ctrl = 0000.
  - op1 and op2 are still driven per the rules above. For an unknown opcode both are 0.
- `out_we` = legal && rd ≠ 0.

## Timing
- Reset values:
  - `out_valid` = 0, `in_ready` = 1.
  - All `out_*` data = 0. Both buffer entries empty.
- Latency: an instruction accepted at edge N appears on `out_*` with `out_valid` = 1 after edge N, when the buffer was empty.
- Transfers:
  - Accept occurs on `in_valid && in_ready`.
  - Consume occurs on `out_valid && out_ready`.
- Buffer: main register plus skid register.
  - `in_ready` = skid empty, registered.
  - Accept while main is full and not consumed → entry goes to skid, `in_ready` falls next cycle.
  - Consume with skid full → skid moves to main, `in_ready` rises next cycle.
  - Simultaneous accept and consume with only main full → new entry goes to main.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
- `out_*` data is stable while `out_valid && !out_ready`.
- Flush:
  - Both entries are empty after the edge. `out_valid` = 0, `in_ready` = 1.
  - An input presented in the flush cycle is discarded even if `in_ready` was 1.
- Reset mid-operation: all entries are discarded immediately (asynchronous).

## Structure
- Shared package `alu_pkg` holds:
  - `alu_ctrl_t` enum of the 12 codes above.
  - Opcode constants `OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`.
  - funct7 constants `F7_BASE` = 0000000, `F7_ALT` = 0100000.
  - A packed `issue_pkt_t` struct {ctrl, op1, op2, rd, we, illegal}.
- Sub-module `alu_op_decoder`: purely combinational. Takes instr, pc, rs1, rs2 and produces `issue_pkt_t`. The top level is the 2-entry skid buffer around it.

## Test plan
- Decode register ops: ADD x3,x1,x2 = 0x002081B3 with rs1 = 5, rs2 = 7 → ctrl 0000, op1 5, op2 7, rd 3, we 1. SUB = 0x402081B3 → ctrl 0001.
- Decode immediate ops:
  - SRAI x5,x6,3 = 0x40335293 → ctrl 1011, op2 0x00000003.
  - ADDI x1,x0,-1 = 0xFFF00093 → ctrl 0000, op2 0xFFFFFFFF.
- Decode upper-immediate ops: LUI x1,0x12345 = 0x123450B7 → ctrl 1111, op2 0x12345000. AUIPC x2,1 at pc 0x100 = 0x00001117 → op1 0x100, op2 0x1000.
- Illegal and rd = 0 cases:
  - 0x0000000B → illegal 1, we 0.
  - 0x402091B3 (SUB funct7 with SLL) → illegal 1.
  - ADD x0 = 0x00208033 → we 0, illegal 0.
- Backpressure: `out_ready` = 0, issue I1, I2, I3 back-to-back. I1 and I2 are accepted; `in_ready` = 0 from the cycle after I2. Raise `out_ready` → I1, I2, I3 delivered in order, with no gaps after the first.
- Flush: with both entries full, assert `flush` together with `in_valid` → next cycle `out_valid` = 0, `in_ready` = 1, and no entry is ever delivered. Assert `rst` with `out_valid` = 1 → `out_valid` falls before the next clock edge.
